// File: rtl/tensor_calc.sv
// tensor_calc: six gradient products summed over a sliding in-row box window.
// Define TENSOR_TT_EN to build the gt*gt (tt) field; otherwise field [0] is 0.
module tensor_calc #(
  parameter int GRAD_WIDTH   = 8,
  parameter int TENSOR_WIDTH = 24,
  parameter int WINDOW       = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_last,
  input  logic signed [GRAD_WIDTH-1:0]   gx,
  input  logic signed [GRAD_WIDTH-1:0]   gy,
  input  logic signed [GRAD_WIDTH-1:0]   gt,
  output logic [TENSOR_WIDTH*6-1:0]      tensors,
  output logic                           out_valid,
  output logic                           out_last
);
  localparam int PW = 2 * GRAD_WIDTH;
  localparam int AW = PW + $clog2(WINDOW) + 1;
  localparam int FW = $clog2(WINDOW + 1);
  localparam int XW = (AW > TENSOR_WIDTH ? AW : TENSOR_WIDTH) + 1;
`ifdef TENSOR_TT_EN
  localparam int LO = 0;
`else
  localparam int LO = 1;
`endif
  localparam logic signed [XW-1:0] SMAX = XW'({1'b0, {(TENSOR_WIDTH-1){1'b1}}});
  localparam logic signed [XW-1:0] SMIN = ~SMAX;

  logic signed [GRAD_WIDTH-1:0] x1, y1, t1;
  logic                         v1, l1, v2, l2;
  logic signed [PW-1:0]         prod [LO:5];
  logic signed [PW-1:0]         hist [LO:5][WINDOW];
  logic signed [AW-1:0]         sum  [LO:5];
  logic signed [AW-1:0]         nxt  [LO:5];
  logic [FW-1:0]                fill;
  logic                         full;

  function automatic logic [TENSOR_WIDTH-1:0] conv(input logic signed [AW-1:0] s);
    logic signed [XW-1:0] w;
    w = XW'(s);
    return w > SMAX ? SMAX[TENSOR_WIDTH-1:0] : w < SMIN ? SMIN[TENSOR_WIDTH-1:0] : w[TENSOR_WIDTH-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x1 <= '0;
      y1 <= '0;
      t1 <= '0;
      v1 <= 1'b0;
      l1 <= 1'b0;
      v2 <= 1'b0;
      l2 <= 1'b0;
      for (int i = LO; i <= 5; i++) prod[i] <= '0;
    end else begin
      x1 <= gx;
      y1 <= gy;
      t1 <= gt;
      v1 <= in_valid;
      l1 <= in_valid & in_last;
      v2 <= v1;
      l2 <= l1;
      prod[5] <= PW'(x1) * PW'(x1);
      prod[4] <= PW'(x1) * PW'(y1);
      prod[3] <= PW'(x1) * PW'(t1);
      prod[2] <= PW'(y1) * PW'(y1);
      prod[1] <= PW'(y1) * PW'(t1);
`ifdef TENSOR_TT_EN
      prod[0] <= PW'(t1) * PW'(t1);
`endif
    end
  end

  // out_last still high means the previous sample closed a row: start from empty state
  assign full = (fill == FW'(WINDOW)) && !out_last;

  always_comb begin
    for (int i = LO; i <= 5; i++)
      nxt[i] = (out_last ? '0 : sum[i]) + AW'(prod[i]) - (full ? AW'(hist[i][WINDOW-1]) : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      fill      <= '0;
      for (int i = LO; i <= 5; i++) begin
        sum[i] <= '0;
        for (int j = 0; j < WINDOW; j++) hist[i][j] <= '0;
      end
    end else begin
      out_valid <= v2;
      out_last  <= l2;
      if (v2) begin
        fill <= out_last ? FW'(1) : (fill == FW'(WINDOW) ? fill : fill + 1'b1);
        for (int i = LO; i <= 5; i++) begin
          sum[i]     <= nxt[i];
          hist[i][0] <= prod[i];
          for (int j = 1; j < WINDOW; j++) hist[i][j] <= out_last ? '0 : hist[i][j-1];
        end
      end else if (out_last) begin
        fill <= '0;
        for (int i = LO; i <= 5; i++) begin
          sum[i] <= '0;
          for (int j = 0; j < WINDOW; j++) hist[i][j] <= '0;
        end
      end
    end
  end

  always_comb begin
    tensors = '0;
    for (int i = LO; i <= 5; i++) tensors[i*TENSOR_WIDTH +: TENSOR_WIDTH] = conv(sum[i]);
  end
endmodule

// File: tb/tb_tensor_calc.sv
// tb_tensor_calc: table-driven check of window sums, row boundaries, latency and async reset.
module tb_tensor_calc;
  localparam int GW = 8;
  localparam int TW = 24;
`ifdef TENSOR_TT_EN
  localparam bit TT_ON = 1'b1;
`else
  localparam bit TT_ON = 1'b0;
`endif

  typedef struct {
    bit v;
    bit l;
    int gx;
    int gy;
    int gt;
    int k;
  } vec_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic signed [GW-1:0] gx = '0, gy = '0, gt = '0;
  logic [TW*6-1:0] tensors;
  logic out_valid, out_last;
  int tests = 0, fails = 0;
  vec_t tbl[$];

  always #5 clk = ~clk;

  tensor_calc #(.GRAD_WIDTH(GW), .TENSOR_WIDTH(TW), .WINDOW(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_last(in_last),
    .gx(gx), .gy(gy), .gt(gt),
    .tensors(tensors), .out_valid(out_valid), .out_last(out_last)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int fld(input int i);
    logic signed [TW-1:0] f;
    f = tensors[i*TW +: TW];
    return int'(f);
  endfunction

  task automatic add(input bit v, input bit l, input int x, input int y, input int t, input int k);
    vec_t e;
    e.v = v; e.l = l; e.gx = x; e.gy = y; e.gt = t; e.k = k;
    tbl.push_back(e);
  endtask

  task automatic drive(input vec_t e);
    in_valid = e.v;
    in_last  = e.l;
    gx = GW'(e.gx);
    gy = GW'(e.gy);
    gt = GW'(e.gt);
  endtask

  task automatic check(input vec_t e, input int n);
    chk($sformatf("out_valid[%0d]", n), out_valid, e.v);
    chk($sformatf("out_last[%0d]", n), out_last, e.v & e.l);
    if (e.v) begin
      chk($sformatf("xx[%0d]", n), fld(5), e.k * e.gx * e.gx);
      chk($sformatf("xy[%0d]", n), fld(4), e.k * e.gx * e.gy);
      chk($sformatf("xt[%0d]", n), fld(3), e.k * e.gx * e.gt);
      chk($sformatf("yy[%0d]", n), fld(2), e.k * e.gy * e.gy);
      chk($sformatf("yt[%0d]", n), fld(1), e.k * e.gy * e.gt);
      chk($sformatf("tt[%0d]", n), fld(0), TT_ON ? e.k * e.gt * e.gt : 0);
      if (e.gx == -128 && e.k == 5) chk("xy_hex", tensors[4*TW +: TW], 24'hFEC280);
    end
  endtask

  initial begin
    vec_t s;
    // row of 7 with last on the 7th, then a back-to-back row of 3
    for (int i = 1; i <= 7; i++) add(1, i == 7, 1, 2, 3, i < 5 ? i : 5);
    for (int i = 1; i <= 3; i++) add(1, i == 3, 1, 2, 3, i);
    // alternating valid, last on the 6th valid sample
    for (int i = 1; i <= 6; i++) begin
      add(1, i == 6, 1, 2, 3, i < 5 ? i : 5);
      if (i < 6) add(0, 1, 9, 9, 9, 0);
    end
    for (int i = 1; i <= 5; i++) add(1, i == 5, -128, 127, 0, i);
    add(0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_tensors", |tensors, 0);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      @(posedge clk);
      #1;
      if (i >= 2) check(tbl[i-2], i - 2);
      else chk($sformatf("pre_valid[%0d]", i), out_valid, 0);
    end

    // async reset after the 3rd sample of a row
    s.v = 1; s.l = 0; s.gx = 1; s.gy = 2; s.gt = 3; s.k = 1;
    for (int i = 0; i < 3; i++) begin
      drive(s);
      @(posedge clk);
      #1;
    end
    chk("pre_rst_xx", fld(5), 1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_tensors", |tensors, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("flushed[%0d]", i), out_valid, 0);
    end
    drive(s);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_early", out_valid, 0);
    @(posedge clk);
    #1;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_xx", fld(5), 1);
    chk("post_rst_yt", fld(1), 6);
    chk("post_rst_last", out_last, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
